// File: rtl/fifo_pkg.sv
// Shared helpers for the multi-port FIFO: counter/pointer widths, modular
// pointer advance without a power-of-two requirement, and lane-count types.
// Purely compile-time and combinational; no state, no backpressure.
package fifo_pkg;

  // Number of lanes granted in one cycle (signed so differences stay simple).
  typedef int lane_cnt_t;

  // Bits needed to hold 0..depth inclusive.
  function automatic int cnt_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to address depth entries (at least one bit).
  function automatic int ptr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Bits needed to hold a popcount of n lanes.
  function automatic int lane_bits(input int n);
    return $clog2(n + 1);
  endfunction

  // ptr + inc modulo depth, assuming ptr < depth and inc <= depth, so one
  // conditional subtract is enough.
  function automatic int wrap_add(input int ptr, input int inc, input int depth);
    int s;
    s = ptr + inc;
    if (s >= depth) s = s - depth;
    return s;
  endfunction

endpackage

// File: rtl/fifo_prefix_grant.sv
// In-order lane grant: lane i granted only if lanes 0..i-1 are granted,
// lane i is requested and fewer than avail lanes precede it.
// Combinational, zero latency; a request gap or exhausted avail stops all higher lanes.
// Ports: req (per-lane request), avail (capacity), grant (per-lane grant), num (popcount of grant).
module fifo_prefix_grant #(
  parameter int N  = 2,
  parameter int AW = 4,
  parameter int CW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [AW-1:0] avail,
  output logic [N-1:0]  grant,
  output logic [CW-1:0] num
);

  logic chain;
  int   n;

  always_comb begin
    grant = '0;
    chain = 1'b1;
    n     = 0;
    for (int i = 0; i < N; i++) begin
      if (chain && req[i] && (i < int'(avail))) begin
        grant[i] = 1'b1;
        n        = n + 1;
      end else begin
        chain = 1'b0;
      end
    end
    num = CW'(n);
  end

endmodule

// File: rtl/fifo_multiport.sv
// Multi-port in-order FIFO: up to NUM_WR pushes and NUM_RD pops per cycle.
// Latency: handshakes are combinational; pushed data is readable the next cycle.
// Backpressure: per-lane wr_valid/rd_valid grants plus a saturating spots credit count.
// Ports: clock/reset (sync, active-high); wr_en/wr_data -> wr_valid; rd_en -> rd_valid/rd_data;
//        status outputs spots, full, count (all from registered occupancy).
// Optional: define FIFO_BYPASS_EN to let read lanes past the stored entries take
//        same-cycle write data directly (those writes are consumed, not stored).
module fifo_multiport
  import fifo_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int WIDTH   = 32,
  parameter int NUM_WR  = 2,
  parameter int NUM_RD  = 2,
  parameter int MAX_CNT = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR-1:0][WIDTH-1:0]     wr_data,
  output logic [NUM_WR-1:0]                wr_valid,
  input  logic [NUM_RD-1:0]                rd_en,
  output logic [NUM_RD-1:0][WIDTH-1:0]     rd_data,
  output logic [NUM_RD-1:0]                rd_valid,
  output logic [$clog2(MAX_CNT+1)-1:0]     spots,
  output logic                             full,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int CNT_W = cnt_bits(DEPTH);
  localparam int PTR_W = ptr_bits(DEPTH);
  localparam int SP_W  = $clog2(MAX_CNT + 1);
  localparam int RL_W  = lane_bits(NUM_RD);
  localparam int WL_W  = lane_bits(NUM_WR);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [NUM_RD-1:0] rd_req;
  logic [NUM_RD-1:0] rd_grant;
  logic [RL_W-1:0]   n_pop;
  logic [NUM_WR-1:0] wr_req;
  logic [WL_W-1:0]   n_push;
  logic [CNT_W-1:0]  free_slots;
  lane_cnt_t         n_byp;
  logic [PTR_W-1:0]  rd_idx [NUM_RD];
  logic [PTR_W-1:0]  wr_idx [NUM_WR];

  // Reset masks every request so no lane is granted and no state moves.
  assign rd_req = reset ? '0 : rd_en;
  assign wr_req = reset ? '0 : wr_en;

  // Stored-entry pops only look at registered occupancy.
  fifo_prefix_grant #(.N(NUM_RD), .AW(CNT_W), .CW(RL_W)) u_rd_grant (
    .req   (rd_req),
    .avail (cnt_q),
    .grant (rd_grant),
    .num   (n_pop)
  );

  // Entries popped this cycle are immediately reusable by writes. Bypassed
  // reads never feed back here, which keeps the write grant loop-free.
  always_comb begin
    free_slots = CNT_W'(DEPTH - int'(cnt_q) + int'(n_pop));
  end

  fifo_prefix_grant #(.N(NUM_WR), .AW(CNT_W), .CW(WL_W)) u_wr_grant (
    .req   (wr_req),
    .avail (free_slots),
    .grant (wr_valid),
    .num   (n_push)
  );

`ifdef FIFO_BYPASS_EN
  logic byp_chain;
`endif

  // Read lane cnt_q+j may continue the in-order chain by taking write lane j,
  // provided every stored entry was popped and that write was accepted.
  always_comb begin
    rd_valid = rd_grant;
    n_byp    = 0;
`ifdef FIFO_BYPASS_EN
    byp_chain = (int'(n_pop) == int'(cnt_q));
    for (int i = 0; i < NUM_RD; i++) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (i == int'(cnt_q) + j) begin
          if (byp_chain && rd_req[i] && wr_valid[j]) begin
            rd_valid[i] = 1'b1;
            n_byp       = n_byp + 1;
          end else begin
            byp_chain = 1'b0;
          end
        end
      end
    end
`endif
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_idx[i]  = PTR_W'(wrap_add(int'(head_q), i, DEPTH));
      rd_data[i] = mem[rd_idx[i]];
`ifdef FIFO_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (i == int'(cnt_q) + j) rd_data[i] = wr_data[j];
      end
`endif
    end
  end

  // Bypassed writes occupy the lowest write lanes; stored writes pack behind tail.
  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      wr_idx[j] = '0;
      if (j >= n_byp) wr_idx[j] = PTR_W'(wrap_add(int'(tail_q), j - n_byp, DEPTH));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= PTR_W'(wrap_add(int'(head_q), int'(n_pop), DEPTH));
      tail_q <= PTR_W'(wrap_add(int'(tail_q), int'(n_push) - n_byp, DEPTH));
      cnt_q  <= CNT_W'(int'(cnt_q) + int'(n_push) - n_byp - int'(n_pop));
    end
  end

  // Storage is never cleared; wr_valid is already low during reset.
  always_ff @(posedge clock) begin
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_valid[j] && (j >= n_byp)) mem[wr_idx[j]] <= wr_data[j];
    end
  end

  always_comb begin
    if (DEPTH - int'(cnt_q) > MAX_CNT) spots = SP_W'(MAX_CNT);
    else                               spots = SP_W'(DEPTH - int'(cnt_q));
  end

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign count = cnt_q;

endmodule

// File: tb/tb_fifo_multiport.sv
`timescale 1ns/1ps
module tb_fifo_multiport;

  localparam int DEPTH   = 8;
  localparam int WIDTH   = 32;
  localparam int NUM_WR  = 2;
  localparam int NUM_RD  = 2;
  localparam int MAX_CNT = 4;

  logic                         clock = 1'b0;
  logic                         reset;
  logic [NUM_WR-1:0]            wr_en;
  logic [NUM_WR-1:0][WIDTH-1:0] wr_data;
  logic [NUM_WR-1:0]            wr_valid;
  logic [NUM_RD-1:0]            rd_en;
  logic [NUM_RD-1:0][WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]            rd_valid;
  logic [2:0]                   spots;
  logic                         full;
  logic [3:0]                   count;

  always #5 clock = ~clock;

  fifo_multiport #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD), .MAX_CNT(MAX_CNT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .spots    (spots),
    .full     (full),
    .count    (count)
  );

  typedef struct {
    int          tag;
    logic [1:0]  wv;
    logic [1:0]  rv;
    logic [31:0] d0;
    logic [31:0] d1;
    int          cnt;
    int          sp;
    logic        full;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_q[$];
  int          n_chk = 0;
  int          n_err = 0;

  function automatic void chk(input string nm, input int tag, input logic [31:0] act,
                              input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s tag=%0d got=%0h want=%0h", nm, tag, act, want);
    end
  endfunction

  // One cycle of stimulus; the expected response comes from a queue model of
  // the FIFO contents and the in-order grant rules.
  task automatic cyc(input int tag, input logic rst, input logic [1:0] we,
                     input logic [31:0] a, input logic [31:0] b, input logic [1:0] re);
    exp_t        e;
    int          cnt, npop, free, npush, nbyp;
    logic [31:0] wd [2];
    logic [31:0] rdv [2];
    @(negedge clock);
    reset      = rst;
    wr_en      = we;
    wr_data[0] = a;
    wr_data[1] = b;
    rd_en      = re;
    wd[0] = a; wd[1] = b;
    rdv[0] = '0; rdv[1] = '0;
    cnt    = model_q.size();
    e.tag  = tag;
    e.cnt  = cnt;
    e.sp   = (DEPTH - cnt > MAX_CNT) ? MAX_CNT : DEPTH - cnt;
    e.full = (cnt == DEPTH);
    e.wv   = '0;
    e.rv   = '0;
    if (rst) begin
      model_q.delete();
    end else begin
      npop = 0;
      for (int i = 0; i < NUM_RD; i++)
        if (re[i] && npop == i && i < cnt) npop++;
      free  = DEPTH - cnt + npop;
      npush = 0;
      for (int j = 0; j < NUM_WR; j++)
        if (we[j] && npush == j && j < free) npush++;
      nbyp = 0;
`ifdef FIFO_BYPASS_EN
      if (npop == cnt)
        for (int i = cnt; i < NUM_RD; i++)
          if (re[i] && nbyp == i - cnt && i - cnt < npush) nbyp++;
`endif
      for (int i = 0; i < npop; i++) begin
        e.rv[i] = 1'b1;
        rdv[i]  = model_q[i];
      end
      for (int k = 0; k < nbyp; k++) begin
        e.rv[cnt+k] = 1'b1;
        rdv[cnt+k]  = wd[k];
      end
      for (int j = 0; j < npush; j++) e.wv[j] = 1'b1;
      repeat (npop) void'(model_q.pop_front());
      for (int j = nbyp; j < npush; j++) model_q.push_back(wd[j]);
    end
    e.d0 = rdv[0];
    e.d1 = rdv[1];
    exp_q.push_back(e);
  endtask

  // Monitor: compares every expected response against the outputs, sampled
  // mid-cycle after the stimulus has settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_valid", e.tag, 32'(wr_valid), 32'(e.wv));
        chk("rd_valid", e.tag, 32'(rd_valid), 32'(e.rv));
        chk("count",    e.tag, 32'(count),    32'(e.cnt));
        chk("spots",    e.tag, 32'(spots),    32'(e.sp));
        chk("full",     e.tag, 32'(full),     32'(e.full));
        if (e.rv[0]) chk("rd_data0", e.tag, rd_data[0], e.d0);
        if (e.rv[1]) chk("rd_data1", e.tag, rd_data[1], e.d1);
      end
    end
  end

  initial begin
    reset   = 1'b1;
    wr_en   = '0;
    wr_data = '0;
    rd_en   = '0;
    repeat (2) @(posedge clock);

    // Reset state, read on empty
    cyc(1, 1, 2'b00, 0, 0, 2'b00);
    cyc(1, 0, 2'b00, 0, 0, 2'b11);
    // Two pushes then two pops, lane order preserved
    cyc(2, 0, 2'b11, 32'hA, 32'hB, 2'b00);
    cyc(2, 0, 2'b00, 0, 0, 2'b11);
    cyc(2, 0, 2'b00, 0, 0, 2'b00);
    // Request gaps block higher lanes
    cyc(3, 0, 2'b10, 32'h11, 32'h12, 2'b00);
    cyc(3, 0, 2'b11, 32'h21, 32'h22, 2'b00);
    cyc(3, 0, 2'b01, 32'h23, 32'h24, 2'b00);
    cyc(3, 0, 2'b00, 0, 0, 2'b10);
    cyc(3, 0, 2'b00, 0, 0, 2'b11);
    cyc(3, 0, 2'b00, 0, 0, 2'b11);
    // Fill to full, write-only stalls, write+read at full proceeds
    for (int k = 0; k < 4; k++) cyc(4, 0, 2'b11, $urandom, $urandom, 2'b00);
    cyc(4, 0, 2'b11, 32'hDEAD, 32'hBEEF, 2'b00);
    cyc(4, 0, 2'b11, 32'h41, 32'h42, 2'b11);
    // One free slot grants only lane 0; then drain past empty
    cyc(5, 0, 2'b00, 0, 0, 2'b01);
    cyc(5, 0, 2'b11, 32'h51, 32'h52, 2'b00);
    for (int k = 0; k < 5; k++) cyc(5, 0, 2'b00, 0, 0, 2'b11);
    // Write+read on empty (bypass-dependent), then reset mid-stream
    cyc(6, 0, 2'b11, 32'hC, 32'hD, 2'b01);
    cyc(6, 0, 2'b00, 0, 0, 2'b01);
    cyc(6, 0, 2'b00, 0, 0, 2'b11);
    cyc(6, 0, 2'b11, 32'h61, 32'h62, 2'b00);
    cyc(6, 1, 2'b11, 32'h63, 32'h64, 2'b11);
    cyc(6, 0, 2'b00, 0, 0, 2'b00);
    // Random traffic with occasional resets
    for (int k = 0; k < 600; k++)
      cyc(7, ($urandom_range(0, 63) == 0), 2'($urandom), $urandom, $urandom, 2'($urandom));
    cyc(8, 0, 2'b00, 0, 0, 2'b00);

    repeat (3) @(negedge clock);
    #3;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
